// File: rtl/lsync_peak_detect_pkg.sv
// lsync_peak_detect_pkg: shared state encoding and default widths for the LTS peak detector
package lsync_peak_detect_pkg;
  localparam int DEF_MAG_W = 11;
  localparam int DEF_IDX_W = 10;
  typedef enum logic [2:0] {IDLE, SEARCH, LOCK1, WAIT2, DONE} state_t;
endpackage

// File: rtl/lsync_peak_detect_if.sv
// lsync_peak_detect_if: sample stream in, sync result out
interface lsync_peak_detect_if import lsync_peak_detect_pkg::*; #(
  parameter int MAG_W = DEF_MAG_W,
  parameter int IDX_W = DEF_IDX_W
);
  logic             start;
  logic             input_strobe;
  logic [MAG_W-1:0] threshold;
  logic [MAG_W-1:0] mag_in;
  logic             sync_found;
  logic             sync_fail;
  logic             busy;
  logic [IDX_W-1:0] peak_idx;
  logic [MAG_W-1:0] peak_val;
  modport master (
    output start, input_strobe, threshold, mag_in,
    input  sync_found, sync_fail, busy, peak_idx, peak_val
  );
  modport slave (
    input  start, input_strobe, threshold, mag_in,
    output sync_found, sync_fail, busy, peak_idx, peak_val
  );
endinterface

// File: rtl/lsync_max_track.sv
// lsync_max_track: running max/argmax with clear; nxt_* is the value including the current sample
module lsync_max_track #(
  parameter int VAL_W = 11,
  parameter int IDX_W = 10
) (
  input  logic             CLK,
  input  logic             s_RST,
  input  logic             clr,
  input  logic             en,
  input  logic [VAL_W-1:0] val,
  input  logic [IDX_W-1:0] idx,
  output logic [VAL_W-1:0] nxt_val,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             nxt_vld
);
  logic [VAL_W-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
  logic             vld;
  logic             take;
  // strict compare keeps the earliest index on ties
  assign take    = en && (!vld || val > max_val);
  assign nxt_val = take ? val : max_val;
  assign nxt_idx = take ? idx : max_idx;
  assign nxt_vld = vld || en;
  always_ff @(posedge CLK)
    if (s_RST || clr) begin
      max_val <= '0;
      max_idx <= '0;
      vld     <= 1'b0;
    end else begin
      max_val <= nxt_val;
      max_idx <= nxt_idx;
      vld     <= nxt_vld;
    end
endmodule

// File: rtl/lsync_peak_detect.sv
// lsync_peak_detect: finds the LTS correlation peak pair and reports the second peak
module lsync_peak_detect import lsync_peak_detect_pkg::*; #(
  parameter int MAG_W    = DEF_MAG_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int SPACING  = 64,
  parameter int TOL      = 1,
  parameter int PEAK_WIN = 4,
  parameter int TIMEOUT  = 320
) (
  input logic                 CLK,
  input logic                 s_RST,
  lsync_peak_detect_if.slave  bus
);
  state_t           state;
  logic [IDX_W-1:0] idx, idx1, win, lo, hi, nxt_idx;
  logic [MAG_W-1:0] nxt_val;
  logic             nxt_vld, ge, in_win, last, decide, clr, en;
  assign ge     = bus.mag_in >= bus.threshold;
  assign lo     = idx1 + IDX_W'(SPACING - TOL);
  assign hi     = idx1 + IDX_W'(SPACING + TOL);
  assign in_win = idx >= lo && idx <= hi;
  assign last   = win + 1'b1 == IDX_W'(PEAK_WIN);
  assign decide = state == WAIT2 && idx == hi;
  // one tracker serves both peaks: it is emptied when the first-peak window closes
  assign clr = bus.start || (bus.input_strobe && ((state == LOCK1 && last) || decide));
  assign en  = bus.input_strobe && !bus.start &&
               ((state == SEARCH && ge) || state == LOCK1 || (state == WAIT2 && in_win && ge));
  lsync_max_track #(.VAL_W(MAG_W), .IDX_W(IDX_W)) u_track (
    .CLK(CLK), .s_RST(s_RST), .clr(clr), .en(en), .val(bus.mag_in), .idx(idx),
    .nxt_val(nxt_val), .nxt_idx(nxt_idx), .nxt_vld(nxt_vld)
  );
  always_ff @(posedge CLK)
    if (s_RST) begin
      state          <= IDLE;
      idx            <= '0;
      idx1           <= '0;
      win            <= '0;
      bus.sync_found <= 1'b0;
      bus.sync_fail  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.peak_idx   <= '0;
      bus.peak_val   <= '0;
    end else begin
      bus.sync_found <= 1'b0;
      bus.sync_fail  <= 1'b0;
      if (bus.start) begin
        state    <= SEARCH;
        idx      <= '0;
        win      <= '0;
        bus.busy <= 1'b1;
      end else if (bus.input_strobe && state != IDLE) begin
        idx <= (idx == '1) ? idx : idx + 1'b1;
        case (state)
          SEARCH:
            if (ge) begin
              state <= LOCK1;
              win   <= IDX_W'(1);
            end else if (idx == IDX_W'(TIMEOUT - 1)) begin
              state         <= IDLE;
              bus.sync_fail <= 1'b1;
              bus.busy      <= 1'b0;
            end
          LOCK1: begin
            win <= win + 1'b1;
            if (last) begin
              state <= WAIT2;
              idx1  <= nxt_idx;
            end
          end
          WAIT2:
            if (decide) begin
              state          <= nxt_vld ? DONE : SEARCH;
              bus.sync_found <= nxt_vld;
              bus.sync_fail  <= !nxt_vld;
              if (nxt_vld) begin
                bus.peak_idx <= nxt_idx;
                bus.peak_val <= nxt_val;
              end
            end
          default: ;
        endcase
      end
    end
endmodule
